// File: rtl/vx_opc_collector.sv
// Multi-slot operand collector: per-bank age-priority GPR reads, in-order dispatch.
// Optional VX_OPC_PERF_EN enables the bank-conflict cycle counter.
module vx_opc_collector #(
    parameter int NUM_COLLECTORS = 2,
    parameter int NUM_BANKS      = 4,
    parameter int NUM_SRCS       = 3,
    parameter int REG_BITS       = 6,
    parameter int WID_BITS       = 4,
    parameter int DATAW          = 128,
    parameter int META_W         = 64,
    parameter int PERF_W         = 32,
    localparam int BANK_BITS     = $clog2(NUM_BANKS),
    localparam int ROW_W         = WID_BITS + REG_BITS - BANK_BITS
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [WID_BITS-1:0]           in_wid_i,
    input  logic [NUM_SRCS*REG_BITS-1:0]  in_rs_i,
    input  logic [NUM_SRCS-1:0]           in_used_i,
    input  logic [META_W-1:0]             in_meta_i,
    output logic [NUM_BANKS-1:0]          gpr_rd_valid_o,
    output logic [NUM_BANKS*ROW_W-1:0]    gpr_rd_addr_o,
    input  logic [NUM_BANKS*DATAW-1:0]    gpr_rd_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [WID_BITS-1:0]           out_wid_o,
    output logic [META_W-1:0]             out_meta_o,
    output logic [NUM_SRCS*DATAW-1:0]     out_data_o,
    output logic [PERF_W-1:0]             perf_conflicts_o
);
    localparam int SLOT_BITS = $clog2(NUM_COLLECTORS);
    localparam int CNT_W     = SLOT_BITS + 1;
    localparam int BB        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int SRC_BITS  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

    typedef enum logic {FREE, COLLECT} slot_state_e;

    slot_state_e          state_q [NUM_COLLECTORS];
    slot_state_e          state_d [NUM_COLLECTORS];
    logic [WID_BITS-1:0]  wid_q   [NUM_COLLECTORS];
    logic [META_W-1:0]    meta_q  [NUM_COLLECTORS];
    logic [REG_BITS-1:0]  reg_q   [NUM_COLLECTORS][NUM_SRCS];
    logic [DATAW-1:0]     data_q  [NUM_COLLECTORS][NUM_SRCS];
    logic [NUM_SRCS-1:0]  need_q  [NUM_COLLECTORS];
    logic [NUM_SRCS-1:0]  issued_q[NUM_COLLECTORS];
    logic [NUM_SRCS-1:0]  done_q  [NUM_COLLECTORS];

    logic [SLOT_BITS-1:0] alloc_ptr_q, alloc_ptr_d, head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [NUM_BANKS-1:0] gnt_vld;
    logic [SLOT_BITS-1:0] gnt_slot   [NUM_BANKS];
    logic [SRC_BITS-1:0]  gnt_src    [NUM_BANKS];
    logic [NUM_BANKS-1:0] tag_vld_q;
    logic [SLOT_BITS-1:0] tag_slot_q [NUM_BANKS];
    logic [SRC_BITS-1:0]  tag_src_q  [NUM_BANKS];
    logic                 any_conflict;

    logic [NUM_SRCS-1:0]  need_in;
    logic                 accept, dispatch;

    function automatic logic [BB-1:0] bank_of(input logic [REG_BITS-1:0] r);
        if (NUM_BANKS == 1) return '0;
        return r[BB-1:0];
    endfunction

    assign in_ready_o  = (count_q < CNT_W'(NUM_COLLECTORS));
    assign out_valid_o = (state_q[head_ptr_q] == COLLECT) && (&done_q[head_ptr_q]);
    assign accept      = in_valid_i && in_ready_o;
    assign dispatch    = out_valid_o && out_ready_i;

    always_comb begin
        for (int i = 0; i < NUM_SRCS; i++)
            need_in[i] = in_used_i[i] && (in_rs_i[i*REG_BITS +: REG_BITS] != '0);
    end

    // Slot FSMs and ring pointers
    always_comb begin
        for (int c = 0; c < NUM_COLLECTORS; c++) state_d[c] = state_q[c];
        if (accept)   state_d[alloc_ptr_q] = COLLECT;
        if (dispatch) state_d[head_ptr_q]  = FREE;
        alloc_ptr_d = alloc_ptr_q + SLOT_BITS'(accept);
        head_ptr_d  = head_ptr_q + SLOT_BITS'(dispatch);
        count_d     = count_q + CNT_W'(accept) - CNT_W'(dispatch);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_COLLECTORS; c++) state_q[c] <= FREE;
            alloc_ptr_q <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            alloc_ptr_q <= alloc_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
        end
    end

    // Per bank: scan slots oldest-first from head, sources in index order.
    always_comb begin : arb
        logic                 found;
        logic [SLOT_BITS-1:0] s;
        found        = 1'b0;
        s            = '0;
        gnt_vld      = '0;
        any_conflict = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_slot[b] = '0;
            gnt_src[b]  = '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            found = 1'b0;
            for (int a = 0; a < NUM_COLLECTORS; a++) begin
                s = head_ptr_q + SLOT_BITS'(a);
                for (int i = 0; i < NUM_SRCS; i++) begin
                    if (state_q[s] == COLLECT && need_q[s][i] && !issued_q[s][i]
                        && bank_of(reg_q[s][i]) == BB'(b)) begin
                        if (found) begin
                            any_conflict = 1'b1;
                        end else begin
                            found       = 1'b1;
                            gnt_vld[b]  = 1'b1;
                            gnt_slot[b] = s;
                            gnt_src[b]  = SRC_BITS'(i);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_COLLECTORS; c++) begin
                wid_q[c]    <= '0;
                meta_q[c]   <= '0;
                need_q[c]   <= '0;
                issued_q[c] <= '0;
                done_q[c]   <= '0;
                for (int i = 0; i < NUM_SRCS; i++) begin
                    reg_q[c][i]  <= '0;
                    data_q[c][i] <= '0;
                end
            end
            tag_vld_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                tag_slot_q[b] <= '0;
                tag_src_q[b]  <= '0;
            end
        end else begin
            if (accept) begin
                wid_q[alloc_ptr_q]    <= in_wid_i;
                meta_q[alloc_ptr_q]   <= in_meta_i;
                need_q[alloc_ptr_q]   <= need_in;
                issued_q[alloc_ptr_q] <= '0;
                done_q[alloc_ptr_q]   <= ~need_in;
                for (int i = 0; i < NUM_SRCS; i++) begin
                    reg_q[alloc_ptr_q][i]  <= in_rs_i[i*REG_BITS +: REG_BITS];
                    data_q[alloc_ptr_q][i] <= '0;
                end
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (gnt_vld[b]) issued_q[gnt_slot[b]][gnt_src[b]] <= 1'b1;
                // Returning data lands one cycle after its strobe, steered by the tag.
                if (tag_vld_q[b]) begin
                    data_q[tag_slot_q[b]][tag_src_q[b]] <= gpr_rd_data_i[b*DATAW +: DATAW];
                    done_q[tag_slot_q[b]][tag_src_q[b]] <= 1'b1;
                end
            end
            tag_vld_q  <= gnt_vld;
            tag_slot_q <= gnt_slot;
            tag_src_q  <= gnt_src;
        end
    end

    assign gpr_rd_valid_o = gnt_vld;
    assign out_wid_o      = wid_q[head_ptr_q];
    assign out_meta_o     = meta_q[head_ptr_q];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign gpr_rd_addr_o[b*ROW_W +: ROW_W] =
            {wid_q[gnt_slot[b]], reg_q[gnt_slot[b]][gnt_src[b]][REG_BITS-1:BANK_BITS]};
    end

    for (genvar i = 0; i < NUM_SRCS; i++) begin : g_src
        assign out_data_o[i*DATAW +: DATAW] = data_q[head_ptr_q][i];
    end

`ifdef VX_OPC_PERF_EN
    logic [PERF_W-1:0] perf_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)           perf_q <= '0;
        else if (any_conflict) perf_q <= perf_q + PERF_W'(1);
    end
    assign perf_conflicts_o = perf_q;
`else
    logic unused_conflict;
    assign unused_conflict  = any_conflict;
    assign perf_conflicts_o = '0;
`endif

endmodule

// File: tb/tb_vx_opc_collector.sv
// Directed bench for vx_opc_collector: vector table plus ordering, full, and reset sequences.
module tb_vx_opc_collector;
    localparam int C = 2, B = 4, S = 3, RB = 6, WB = 4, DW = 128, MW = 64, PW = 32;
    localparam int BB = 2, RW = WB + RB - BB;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0, in_ready;
    logic [WB-1:0]     in_wid = '0;
    logic [S*RB-1:0]   in_rs = '0;
    logic [S-1:0]      in_used = '0;
    logic [MW-1:0]     in_meta = '0;
    logic [B-1:0]      gpr_rd_valid;
    logic [B*RW-1:0]   gpr_rd_addr;
    logic [B*DW-1:0]   gpr_rd_data = '0;
    logic              out_valid, out_ready = 1'b0;
    logic [WB-1:0]     out_wid;
    logic [MW-1:0]     out_meta;
    logic [S*DW-1:0]   out_data;
    logic [PW-1:0]     perf;

    always #5 clk = ~clk;

    vx_opc_collector dut (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_wid_i(in_wid),
        .in_rs_i(in_rs), .in_used_i(in_used), .in_meta_i(in_meta),
        .gpr_rd_valid_o(gpr_rd_valid), .gpr_rd_addr_o(gpr_rd_addr), .gpr_rd_data_i(gpr_rd_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_wid_o(out_wid),
        .out_meta_o(out_meta), .out_data_o(out_data), .perf_conflicts_o(perf)
    );

    // GPR model: row data = 0xA0 + reg, with wid placed at bit 16.
    function automatic logic [DW-1:0] gpr_val(input int b, input logic [RW-1:0] a);
        logic [RB-1:0] r;
        r = {a[RB-BB-1:0], 2'(b)};
        return DW'(32'hA0 + 32'(r)) | (DW'(a[RW-1 -: WB]) << 16);
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < B; b++)
            gpr_rd_data[b*DW +: DW] <= gpr_rd_valid[b] ? gpr_val(b, gpr_rd_addr[b*RW +: RW])
                                                        : {4{32'hDEADBEEF}};
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [WB-1:0] wid;
        logic [S-1:0]  used;
        logic [RB-1:0] rs0, rs1, rs2;
        int            lat;
        logic [B-1:0]  mask;
        logic [31:0]   d0, d1, d2;
        int            perf;
    } vec_t;

    vec_t vt[7];

    // Accept at cycle 0 (current negedge), measure latency, check outputs, then dispatch.
    task automatic run_vec(input vec_t v, input string nm);
        logic [PW-1:0]   p0;
        logic [S*DW-1:0] exp;
        int              cyc;
        int              ep;
        p0       = perf;
        in_valid = 1'b1;
        in_wid   = v.wid;
        in_used  = v.used;
        in_rs    = {v.rs2, v.rs1, v.rs0};
        in_meta  = {32'hC0DEF00D, 28'd0, v.wid};
        step;
        in_valid = 1'b0;
        cyc = 1;
        chk({nm, " strobe"}, 512'(gpr_rd_valid), 512'(v.mask));
        while (!out_valid && cyc < 20) begin
            step;
            cyc++;
        end
        chk({nm, " latency"}, 512'(cyc), 512'(v.lat));
        exp = {DW'(v.d2), DW'(v.d1), DW'(v.d0)};
        chk({nm, " data"}, 512'(out_data), 512'(exp));
        chk({nm, " wid/meta"}, 512'({out_wid, out_meta}), 512'({v.wid, 32'hC0DEF00D, 28'd0, v.wid}));
`ifdef VX_OPC_PERF_EN
        ep = v.perf;
`else
        ep = 0;
`endif
        chk({nm, " perf"}, 512'(perf - p0), 512'(32'(ep)));
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " in_ready"}, 512'(in_ready), 512'(1));
        chk({nm, " out_valid"}, 512'(out_valid), 512'(0));
        chk({nm, " gpr_rd_valid"}, 512'(gpr_rd_valid), 512'(0));
        chk({nm, " perf"}, 512'(perf), 512'(0));
        chk({nm, " out_data"}, 512'(out_data), 512'(0));
        chk({nm, " out_wid/meta"}, 512'({out_wid, out_meta}), 512'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [S*DW-1:0] ea, eb;
        vec_t fresh;
        //           wid    used    rs0    rs1    rs2  lat mask     d0         d1         d2     perf
        vt[0] = '{4'd0, 3'b000, 6'd1,  6'd2,  6'd3, 1, 4'b0000, 32'h0,     32'h0,     32'h0,     0};
        vt[1] = '{4'd0, 3'b111, 6'd1,  6'd2,  6'd3, 3, 4'b1110, 32'hA1,    32'hA2,    32'hA3,    0};
        vt[2] = '{4'd0, 3'b111, 6'd1,  6'd5,  6'd9, 5, 4'b0010, 32'hA1,    32'hA5,    32'hA9,    2};
        vt[3] = '{4'd0, 3'b111, 6'd0,  6'd4,  6'd8, 4, 4'b0001, 32'h0,     32'hA4,    32'hA8,    1};
        vt[4] = '{4'd0, 3'b010, 6'd5,  6'd6,  6'd7, 3, 4'b0100, 32'h0,     32'hA6,    32'h0,     0};
        vt[5] = '{4'd3, 3'b011, 6'd13, 6'd2,  6'd7, 3, 4'b0110, 32'h300AD, 32'h300A2, 32'h0,     0};
        vt[6] = '{4'd0, 3'b100, 6'd1,  6'd2,  6'd3, 3, 4'b1000, 32'h0,     32'h0,     32'hA3,    0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("reset");

        for (int k = 0; k < 7; k++) run_vec(vt[k], $sformatf("vec%0d", k));

        // In-order dispatch: A (3 bank-1 reads) then B (1 bank-2 read), B finishes first.
        ea = {DW'(32'h100A9), DW'(32'h100A5), DW'(32'h100A1)};
        eb = {DW'(0), DW'(0), DW'(32'h200A2)};
        in_valid = 1'b1; in_wid = 4'd1; in_used = 3'b111; in_rs = {6'd9, 6'd5, 6'd1};
        step;
        in_wid = 4'd2; in_used = 3'b001; in_rs = {6'd0, 6'd0, 6'd2};
        step;
        in_valid = 1'b0;
        step;
        step;
        chk("order no-bypass", 512'(out_valid), 512'(0));
        step;
        chk("order head A", 512'({out_valid, out_wid, out_data}), 512'({1'b1, 4'd1, ea}));
        for (int k = 0; k < 4; k++) begin
            step;
            chk($sformatf("order hold%0d", k), 512'({out_valid, out_wid, out_data}), 512'({1'b1, 4'd1, ea}));
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("order head B", 512'({out_valid, out_wid, out_data}), 512'({1'b1, 4'd2, eb}));
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("order empty", 512'(out_valid), 512'(0));

        // Realign alloc_ptr to 0 so the full test wraps back onto slot 0.
        run_vec(vt[0], "realign");

        in_valid = 1'b1; in_used = 3'b000; in_wid = 4'd5;
        step;
        in_wid = 4'd6;
        step;
        in_valid = 1'b0;
        chk("full in_ready", 512'(in_ready), 512'(0));
        chk("full head", 512'({out_valid, out_wid}), 512'({1'b1, 4'd5}));
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("freed in_ready", 512'(in_ready), 512'(1));
        chk("freed head", 512'({out_valid, out_wid}), 512'({1'b1, 4'd6}));
        in_valid = 1'b1; in_wid = 4'd7;
        step;
        in_valid = 1'b0;
        chk("refull in_ready", 512'(in_ready), 512'(0));
        out_ready = 1'b1;
        step;
        chk("wrap head", 512'({out_valid, out_wid, out_data}), 512'({1'b1, 4'd7, {S*DW{1'b0}}}));
        step;
        out_ready = 1'b0;
        chk("wrap drained", 512'({out_valid, in_ready}), 512'({1'b0, 1'b1}));

        // Reset mid-flight right after the first strobe; stale return must be ignored.
        in_valid = 1'b1; in_wid = 4'd1; in_used = 3'b111; in_rs = {6'd9, 6'd5, 6'd1};
        step;
        in_valid = 1'b0;
        chk("midrst strobe", 512'(gpr_rd_valid), 512'(4'b0010));
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("midrst");
        fresh = '{4'd4, 3'b001, 6'd6, 6'd0, 6'd0, 3, 4'b0100, 32'h400A6, 32'h0, 32'h0, 0};
        run_vec(fresh, "postrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
